// File: rtl/alu4_exec.sv
// Registered command/response wrapper around the combinational alu4, with a 2-entry response FIFO.
// Optional operand chaining is enabled by defining ALU4_EXEC_CHAIN_EN.

module alu4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [2:0] i_op,
  output logic [3:0] o_result,
  output logic [3:0] o_flags
);
  logic [4:0] w_sum;
  logic       w_c;
  logic       w_v;

  // Opcode decode; only add/sub produce carry and overflow.
  always_comb begin
    w_sum    = 5'd0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    o_result = 4'd0;
    case (i_op)
      3'b000: o_result = ~i_a;
      3'b001: o_result = ~i_b;
      3'b010: o_result = i_a & i_b;
      3'b011: o_result = i_a | i_b;
      3'b100: o_result = i_a ^ i_b;
      3'b101: o_result = ~(i_a ^ i_b);
      3'b110: begin
        w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + 5'd1;
        o_result = w_sum[3:0];
        w_c      = w_sum[4];
        w_v      = (i_a[3] != i_b[3]) && (w_sum[3] != i_a[3]);
      end
      3'b111: begin
        w_sum    = {1'b0, i_a} + {1'b0, i_b};
        o_result = w_sum[3:0];
        w_c      = w_sum[4];
        w_v      = (i_a[3] == i_b[3]) && (w_sum[3] != i_a[3]);
      end
      default: o_result = 4'd0;
    endcase
  end

  assign o_flags = {w_c, o_result[3], (o_result == 4'd0), w_v};
endmodule

module alu4_exec #(
  parameter int RSP_DEPTH = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [CNT_W-1:0] op_cnt,
  output logic             sticky_v,
  input  logic             clr_sticky
`ifdef ALU4_EXEC_CHAIN_EN
  ,
  input  logic             cmd_chain
`endif
);
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'(RSP_DEPTH)
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_head_res;
  logic [3:0]       r_head_flg;
  logic [3:0]       r_tail_res;
  logic [3:0]       r_tail_flg;
  logic [CNT_W-1:0] r_op_cnt;
  logic             r_sticky;
  logic [3:0]       w_a;
  logic [3:0]       w_res;
  logic [3:0]       w_flg;
  logic             w_push;
  logic             w_pop;

`ifdef ALU4_EXEC_CHAIN_EN
  logic [3:0] r_last_result;

  assign w_a = cmd_chain ? r_last_result : cmd_a;

  // Remembers the result of the most recent accept for chained operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_result <= 4'd0;
    end else if (w_push) begin
      r_last_result <= w_res;
    end
  end
`else
  assign w_a = cmd_a;
`endif

  alu4 u_alu4 (
    .i_a      (w_a),
    .i_b      (cmd_b),
    .i_op     (cmd_op),
    .o_result (w_res),
    .o_flags  (w_flg)
  );

  // Ready depends only on registered state, so there is no path from rsp_ready.
  assign cmd_ready  = (r_state != ST_FULL);
  assign rsp_valid  = (r_state != ST_EMPTY);
  assign w_push     = cmd_valid && cmd_ready;
  assign w_pop      = rsp_ready && rsp_valid;
  assign rsp_result = r_head_res;
  assign rsp_flags  = r_head_flg;
  assign op_cnt     = r_op_cnt;
  assign sticky_v   = r_sticky;

  // Buffer occupancy state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Occupancy transitions; FULL cannot push because cmd_ready is low there.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) w_state_nxt = ST_ONE;
        else        w_state_nxt = ST_EMPTY;
      end
      ST_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = ST_FULL;
        else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
        else                       w_state_nxt = ST_ONE;
      end
      ST_FULL: begin
        if (w_pop) w_state_nxt = ST_ONE;
        else       w_state_nxt = ST_FULL;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Head/tail storage; the head register drives the response outputs directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head_res <= 4'd0;
      r_head_flg <= 4'd0;
      r_tail_res <= 4'd0;
      r_tail_flg <= 4'd0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_head_res <= w_res;
            r_head_flg <= w_flg;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            r_head_res <= w_res;
            r_head_flg <= w_flg;
          end else if (w_push) begin
            r_tail_res <= w_res;
            r_tail_flg <= w_flg;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_head_res <= r_tail_res;
            r_head_flg <= r_tail_flg;
          end
        end
        default: begin
          r_head_res <= 4'd0;
          r_head_flg <= 4'd0;
        end
      endcase
    end
  end

  // Accept counter and overflow sticky bit (a set beats a simultaneous clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_cnt <= '0;
      r_sticky <= 1'b0;
    end else begin
      if (w_push) begin
        r_op_cnt <= r_op_cnt + CNT_W'(1);
      end
      if (w_push && w_flg[0]) begin
        r_sticky <= 1'b1;
      end else if (clr_sticky) begin
        r_sticky <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu4_exec.sv
// Self-checking bench for alu4_exec: queue-based reference model compared every cycle,
// plus directed vectors with hand-computed expectations.

module tb_alu4_exec;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = 4'd0;
  logic [3:0] cmd_b = 4'd0;
  logic [2:0] cmd_op = 3'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_result;
  logic [3:0] rsp_flags;
  logic [7:0] op_cnt;
  logic       sticky_v;
  logic       clr_sticky = 1'b0;
`ifdef ALU4_EXEC_CHAIN_EN
  logic       cmd_chain = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  alu4_exec #(.RSP_DEPTH(2), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .op_cnt     (op_cnt),
    .sticky_v   (sticky_v),
    .clr_sticky (clr_sticky)
`ifdef ALU4_EXEC_CHAIN_EN
    ,
    .cmd_chain  (cmd_chain)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: {result, c, n, z, v} from plain integer arithmetic.
  function automatic logic [7:0] model_alu(input int a, input int b, input int op);
    int r, sa, sb, sr;
    logic c, v;
    c  = 1'b0;
    v  = 1'b0;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    case (op)
      0: r = 15 - a;
      1: r = 15 - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - (a ^ b);
      6: begin
        r  = (a - b + 16) % 16;
        c  = (a >= b);
        sr = sa - sb;
        v  = (sr > 7) || (sr < -8);
      end
      default: begin
        r  = (a + b) % 16;
        c  = (a + b) > 15;
        sr = sa + sb;
        v  = (sr > 7) || (sr < -8);
      end
    endcase
    return {r[3:0], c, r[3], (r == 0), v};
  endfunction

  logic [7:0] q[$];
  logic [7:0] m_cnt = 8'd0;
  logic       m_sticky = 1'b0;
  logic [3:0] m_last = 4'd0;

  // Reference model advances on each clock edge from the inputs held since the last negedge.
  always @(posedge clk or posedge reset) begin
    logic acc, pop, use_chain;
    logic [7:0] e;
    if (reset) begin
      q.delete();
      m_cnt    = 8'd0;
      m_sticky = 1'b0;
      m_last   = 4'd0;
    end else begin
      acc = cmd_valid && (q.size() < 2);
      pop = rsp_ready && (q.size() > 0);
      use_chain = 1'b0;
`ifdef ALU4_EXEC_CHAIN_EN
      use_chain = cmd_chain;
`endif
      if (pop) void'(q.pop_front());
      if (acc) begin
        e = model_alu(use_chain ? int'(m_last) : int'(cmd_a), int'(cmd_b), int'(cmd_op));
        q.push_back(e);
        m_last = e[7:4];
        m_cnt  = m_cnt + 8'd1;
      end
      if (acc && e[0]) m_sticky = 1'b1;
      else if (clr_sticky) m_sticky = 1'b0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
      check("cmd_ready", 32'(cmd_ready), 32'(q.size() < 2));
      if (q.size() != 0) begin
        check("rsp_result", 32'(rsp_result), 32'(q[0][7:4]));
        check("rsp_flags", 32'(rsp_flags), 32'(q[0][3:0]));
      end
      check("op_cnt", 32'(op_cnt), 32'(m_cnt));
      check("sticky_v", 32'(sticky_v), 32'(m_sticky));
    end
  end

  task automatic cyc(input logic v, input logic [3:0] a, input logic [3:0] b,
                     input logic [2:0] op, input logic rr, input logic clr);
    cmd_valid  = v;
    cmd_a      = a;
    cmd_b      = b;
    cmd_op     = op;
    rsp_ready  = rr;
    clr_sticky = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_cnt", 32'(op_cnt), 32'd0);
    check("rst_res", 32'({rsp_result, rsp_flags, sticky_v}), 32'd0);

    // 8 - 5: overflow with no borrow
    cyc(1'b1, 4'b1000, 4'b0101, 3'b110, 1'b0, 1'b0);
    check("sub_valid", 32'(rsp_valid), 32'd1);
    check("sub_res", 32'(rsp_result), 32'h3);
    check("sub_flg", 32'(rsp_flags), 32'b1001);
    check("sub_sticky", 32'(sticky_v), 32'd1);
    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0);
    check("pop_empty", 32'(rsp_valid), 32'd0);

    cyc(1'b1, 4'b1000, 4'b0101, 3'b111, 1'b1, 1'b0);
    check("add_res", 32'(rsp_result), 32'hd);
    check("add_flg", 32'(rsp_flags), 32'b0100);
    // push and pop together while holding one entry
    cyc(1'b1, 4'b0101, 4'b1001, 3'b010, 1'b1, 1'b0);
    check("and_res", 32'(rsp_result), 32'h1);
    check("and_flg", 32'(rsp_flags), 32'b0000);
    check("pp_ready", 32'(cmd_ready), 32'd1);
    check("pp_cnt", 32'(op_cnt), 32'd3);
    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0);

    // Backpressure
    cyc(1'b1, 4'd1, 4'd1, 3'b111, 1'b0, 1'b0);
    cyc(1'b1, 4'd2, 4'd3, 3'b111, 1'b0, 1'b0);
    check("bp_ready0", 32'(cmd_ready), 32'd0);
    check("bp_head", 32'(rsp_result), 32'h2);
    cyc(1'b1, 4'd4, 4'd4, 3'b111, 1'b0, 1'b0);
    check("bp_held", 32'(op_cnt), 32'd5);
    check("bp_stable", 32'(rsp_result), 32'h2);
    cyc(1'b1, 4'd4, 4'd4, 3'b111, 1'b1, 1'b0);
    check("bp_pop1", 32'(rsp_result), 32'h5);
    check("bp_cnt1", 32'(op_cnt), 32'd5);
    cyc(1'b1, 4'd4, 4'd4, 3'b111, 1'b1, 1'b0);
    check("bp_third", 32'(rsp_result), 32'h8);
    check("bp_third_flg", 32'(rsp_flags), 32'b0101);
    check("bp_cnt2", 32'(op_cnt), 32'd6);
    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b1);
    check("clr_sticky", 32'(sticky_v), 32'd0);
    // set wins over clear
    cyc(1'b1, 4'b1000, 4'b0101, 3'b110, 1'b0, 1'b1);
    check("set_wins", 32'(sticky_v), 32'd1);
    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0);

    // Counter wrap: 7 so far, 249 more reaches 256
    for (int i = 0; i < 249; i++) begin
      cyc(1'b1, 4'(i), 4'(i >> 4), 3'(i % 8), 1'b1, 1'b0);
    end
    check("cnt_wrap", 32'(op_cnt), 32'd0);

    cyc(1'b1, 4'b0011, 4'b0011, 3'b100, 1'b1, 1'b0);
    check("xor_zero_res", 32'(rsp_result), 32'h0);
    check("xor_zero_flg", 32'(rsp_flags), 32'b0010);

    // Asynchronous reset with the buffer full
    cyc(1'b1, 4'd1, 4'd2, 3'b111, 1'b0, 1'b0);
    check("full_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(rsp_valid), 32'd0);
    check("arst_cnt", 32'(op_cnt), 32'd0);
    check("arst_res", 32'({rsp_result, rsp_flags, sticky_v}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

`ifdef ALU4_EXEC_CHAIN_EN
    cyc(1'b1, 4'b0011, 4'b0001, 3'b111, 1'b1, 1'b0);
    check("chain_seed", 32'(rsp_result), 32'h4);
    cmd_chain = 1'b1;
    cyc(1'b1, 4'b1111, 4'b0010, 3'b111, 1'b1, 1'b0);
    cmd_chain = 1'b0;
    check("chain_res", 32'(rsp_result), 32'h6);
`endif

    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu4_exec.md
Name: alu4_exec

Overview:
Registered command/response execution unit built around the existing combinational alu4 (instantiated internally, unchanged). Accepts operand/opcode commands over a valid/ready channel, computes through alu4, and returns result plus flags over a second valid/ready channel. Replaces bench-driven stimulus with a hardware-side consumer, so a sequencer or CPU datapath can issue ALU operations with backpressure.

Parameters:
RSP_DEPTH, 2, response buffer entries (fixed at 2; count register is 2 bits)
CNT_W, 8, width of the accepted-operation counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  unit can accept a command
cmd_a  input  4  operand A
cmd_b  input  4  operand B
cmd_op  input  3  opcode (alu4 encoding)
rsp_valid  output  1  response buffer head is valid
rsp_ready  input  1  consumer takes the head this cycle
rsp_result  output  4  head result
rsp_flags  output  4  head flags {c,n,z,v}
op_cnt  output  CNT_W  number of accepted commands, wraps
sticky_v  output  1  set by any pushed response with v=1
clr_sticky  input  1  clears sticky_v

Behaviour:
- Opcodes: 000 ~A, 001 ~B, 010 A&B, 011 A|B, 100 A^B, 101 ~(A^B), 110 A-B, 111 A+B.
- Flags from alu4: n=result[3], z=(result==0). For add/sub, c=carry-out (sub is A+~B+1, so c=1 means no borrow) and v=signed overflow. For logic ops, c=0 and v=0.
- Accept: the handshake fires when cmd_valid && cmd_ready. alu4 is driven directly from the cmd_* inputs. On accept, {result,flags} is pushed into the response buffer at the same clock edge.
- Latency: a command accepted at edge T drives rsp_valid=1 after edge T when the buffer was empty. Latency is 1 cycle, with no combinational path from cmd_* to rsp_*.
- Buffer: 2-entry FIFO with count-based state machine EMPTY(0), ONE(1), FULL(2).
  - rsp_valid = (count != 0).
  - cmd_ready = (count != FULL). cmd_ready is registered-state only and is low when FULL even if rsp_ready=1 that cycle. There is no combinational ready path.
- Transitions:
  - EMPTY with push → ONE.
  - ONE with push only → FULL.
  - ONE with pop only → EMPTY.
  - ONE with push and pop → ONE (head replaced by the new entry).
  - FULL with pop → ONE.
  - A pop in EMPTY is ignored.
- Ordering: strict FIFO. rsp_result and rsp_flags are stable while rsp_valid && !rsp_ready.
- op_cnt increments on every accept and wraps 0xFF→0x00 (for CNT_W=8).
- sticky_v is set when a pushed entry has v=1 and cleared by clr_sticky. If set and clear occur in the same cycle, set wins.
- Reset (async, any time including mid-transfer): count=EMPTY, rsp_valid=0, cmd_ready=1 from reset release onward, rsp_result=0, rsp_flags=0, op_cnt=0, sticky_v=0. Buffered entries are discarded. Outputs go to reset values immediately on reset assertion, without waiting for a clock edge.
- Invalid opcodes do not exist (3-bit fully decoded). X on cmd_* while cmd_valid=0 must not affect state.

Optional Feature:
ALU4_EXEC_CHAIN_EN
- With the macro defined:
  - Adds input cmd_chain (1 bit).
  - When an accepted command has cmd_chain=1, operand A is the result of the most recently accepted command (an internal last_result register, reset 0) instead of cmd_a.
  - last_result updates on every accept, chained or not.
- Without the macro: port cmd_chain and register last_result are absent, and A is always cmd_a.

Test Plan:
- Reset, then accept a=1000 b=0101 op=110. The next cycle, rsp_valid=1, result=0011, flags c=1 n=0 z=0 v=1, and sticky_v=1.
- Accept a=1000 b=0101 op=111 → result=1101, c=0 n=1 z=0 v=0. Accept a=0101 b=1001 op=010 → result=0001, c=0 v=0.
- Backpressure: hold rsp_ready=0 and push 3 commands. cmd_ready drops after 2 accepts, and the third is held. Release rsp_ready: responses pop in order and the third is accepted once count<2. The held head stays stable while stalled.
- Simultaneous push/pop in ONE: count stays 1, the order is correct, op_cnt increments. Then apply clr_sticky in the same cycle as a v=1 push → sticky_v remains 1.
- Counter wrap: 256 accepts → op_cnt returns to 0x00. Logic op with result 0 (a=0011 b=0011 op=100) → z=1, n=0.
- Assert reset with FULL buffer mid-stream → rsp_valid=0 immediately, op_cnt=0. With ALU4_EXEC_CHAIN_EN: accept 0011+0001 (add), then chained op=111 with b=0010 → result=0110.
